// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  // Overflow behaviour selected by mode_i
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Count direction selected by up_i
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Ceiling log2; sizes the prescaler phase register (value >= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 32'd1;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 32'd0) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: counts enabled cycles modulo PRESCALE and flags the enabled
// cycle on which the phase sits at PRESCALE-1 (the cycle a step is allowed).
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 32'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int unsigned   PW   = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          at_last_s;

  assign at_last_s = (phase_q == LAST);

  // Phase advances on enabled cycles, wraps after LAST, clears on clr_i
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = {PW{1'b0}};
    end else if (en_i) begin
      if (at_last_s) begin
        phase_d = {PW{1'b0}};
      end else begin
        phase_d = phase_q + PW'(1'b1);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= {PW{1'b0}};
    end else begin
      phase_q <= phase_d;
    end
  end

  assign step_o = en_i & at_last_s & ~clr_i;

endmodule

// File: rtl/up_down_counter_n.sv
// Parametrised up/down counter with load, wrap/saturate modes, registered
// terminal-count pulse and sticky overflow flag.
// Optional feature macro: COUNTER_PRESCALE_EN (one step per PRESCALE enabled
// cycles). Without it every enabled cycle steps and PRESCALE is ignored.
module up_down_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32'd4,
  parameter longint unsigned MODULUS   = 64'd16,
  parameter longint unsigned RESET_VAL = 64'd0,
  parameter int unsigned     PRESCALE  = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);

  // Top of range held one bit wider so MODULUS = 2**WIDTH still fits.
  localparam logic [WIDTH:0]   MAX_C = (WIDTH + 1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             step_s;
  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH:0]   dec_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             boundary_s;

`ifdef COUNTER_PRESCALE_EN
  logic presc_step_s;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (load_i),
    .step_o (presc_step_s)
  );

  assign step_s = presc_step_s & ~load_i;
`else
  logic prescale_unused_s;
  assign prescale_unused_s = PRESCALE[0];
  assign step_s = en_i & ~load_i;
`endif

  assign count_ext_s = {1'b0, count_q};
  assign load_ext_s  = {1'b0, load_val_i};
  assign inc_s       = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s       = count_ext_s - {{WIDTH{1'b0}}, 1'b1};
  assign at_max_s    = (count_ext_s == MAX_C);
  assign at_zero_s   = (count_q == {WIDTH{1'b0}});
  assign boundary_s  = step_s & ((up_i == DIR_UP) ? at_max_s : at_zero_s);

  // Next count and terminal-count: load beats step, step beats hold
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_i) begin
      if (load_ext_s > MAX_C) begin
        count_d = MAX_C[WIDTH-1:0];
      end else begin
        count_d = load_val_i;
      end
      tc_d = 1'b0;
    end else if (step_s) begin
      tc_d = boundary_s;
      if (up_i == DIR_UP) begin
        if (at_max_s) begin
          if (mode_i == MODE_SAT) begin
            count_d = count_q;
          end else begin
            count_d = {WIDTH{1'b0}};
          end
        end else begin
          count_d = inc_s[WIDTH-1:0];
        end
      end else begin
        if (at_zero_s) begin
          if (mode_i == MODE_SAT) begin
            count_d = count_q;
          end else begin
            count_d = MAX_C[WIDTH-1:0];
          end
        end else begin
          count_d = dec_s[WIDTH-1:0];
        end
      end
    end else begin
      count_d = count_q;
      tc_d    = 1'b0;
    end
  end

  // Sticky overflow: a boundary step sets it and beats a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (boundary_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_C;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_up_down_counter_n.sv
// Bench for up_down_counter_n: two instances (MODULUS 16 and 10) share the
// stimulus; a plain-arithmetic model is compared on every cycle and directed
// literal expectations pin the model.
module tb_up_down_counter_n;

  localparam int PRE = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       mode;
  logic       load;
  logic [3:0] lv;
  logic       clr;

  logic [3:0] cnt_a;
  logic       tc_a;
  logic       ovf_a;
  logic [3:0] cnt_b;
  logic       tc_b;
  logic       ovf_b;

  int checks;
  int failures;

  int mods  [2];
  int m_cnt [2];
  int m_tc  [2];
  int m_ovf [2];
  int m_ph  [2];

  up_down_counter_n #(
    .WIDTH(4), .MODULUS(64'd16), .RESET_VAL(64'd0), .PRESCALE(PRE)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .up_i(up), .mode_i(mode),
    .load_i(load), .load_val_i(lv), .clr_ovf_i(clr),
    .count_o(cnt_a), .tc_o(tc_a), .ovf_o(ovf_a)
  );

  up_down_counter_n #(
    .WIDTH(4), .MODULUS(64'd10), .RESET_VAL(64'd0), .PRESCALE(PRE)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .up_i(up), .mode_i(mode),
    .load_i(load), .load_val_i(lv), .clr_ovf_i(clr),
    .count_o(cnt_b), .tc_o(tc_b), .ovf_o(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_tc[d]  = 0;
      m_ovf[d] = 0;
      m_ph[d]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs as sampled.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int  mx;
      bit  stp;
      bit  bnd;
      mx  = mods[d] - 1;
      stp = 1'b0;
      bnd = 1'b0;
      if (!rst_n) begin
        m_cnt[d] = 0; m_tc[d] = 0; m_ovf[d] = 0; m_ph[d] = 0;
      end else begin
        if (load) begin
          m_cnt[d] = (int'(lv) > mx) ? mx : int'(lv);
          m_ph[d]  = 0;
        end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
          if (m_ph[d] == PRE - 1) begin
            stp = 1'b1;
            m_ph[d] = 0;
          end else begin
            m_ph[d] = m_ph[d] + 1;
          end
`else
          stp = 1'b1;
`endif
        end
        if (stp) begin
          if (up) begin
            if (m_cnt[d] == mx) begin
              bnd = 1'b1;
              if (!mode) m_cnt[d] = 0;
            end else begin
              m_cnt[d] = m_cnt[d] + 1;
            end
          end else begin
            if (m_cnt[d] == 0) begin
              bnd = 1'b1;
              if (!mode) m_cnt[d] = mx;
            end else begin
              m_cnt[d] = m_cnt[d] - 1;
            end
          end
        end
        m_tc[d] = bnd ? 1 : 0;
        if (bnd) m_ovf[d] = 1;
        else if (clr) m_ovf[d] = 0;
      end
    end
  endtask

  task automatic check_model();
    check("model_cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
    check("model_tc_a",  32'(tc_a),  32'(m_tc[0]));
    check("model_ovf_a", 32'(ovf_a), 32'(m_ovf[0]));
    check("model_cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
    check("model_tc_b",  32'(tc_b),  32'(m_tc[1]));
    check("model_ovf_b", 32'(ovf_b), 32'(m_ovf[1]));
  endtask

  // One clock: edge, model update, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(input logic e, input logic u, input logic m,
                        input logic l, input logic [3:0] v, input logic c);
    en = e; up = u; mode = m; load = l; lv = v; clr = c;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mods[0]  = 16;
    mods[1]  = 10;
    rst_n    = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    model_reset();
    tick();
    tick();
    check("reset_cnt_a", 32'(cnt_a), 32'd0);
    check("reset_tc_a",  32'(tc_a),  32'd0);
    check("reset_ovf_a", 32'(ovf_a), 32'd0);
    rst_n = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    // One step per PRE enabled cycles
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("presc_cnt_a", 32'(cnt_a), 32'(k / 4));
      check("presc_tc_a",  32'(tc_a),  32'd0);
    end
    // Load clears phase
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("presc_load_cnt_a", 32'(cnt_a), (k == 4) ? 32'd4 : 32'd3);
    end
    // Phase holds while en is low
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    check("presc_hold_cnt_a", 32'(cnt_a), 32'd4);
    tick();
    check("presc_step_cnt_a", 32'(cnt_a), 32'd5);
`else
    // Wrap up over 17 cycles
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("wrap_cnt_a", 32'(cnt_a), 32'(k % 16));
      check("wrap_tc_a",  32'(tc_a),  (k == 16) ? 32'd1 : 32'd0);
      check("wrap_ovf_a", 32'(ovf_a), (k >= 16) ? 32'd1 : 32'd0);
    end

    // Clear coinciding with boundary: set wins, then clear alone
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
    tick();
    check("clamp15_cnt_b", 32'(cnt_b), 32'd9);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    check("setwins_cnt_a", 32'(cnt_a), 32'd0);
    check("setwins_tc_a",  32'(tc_a),  32'd1);
    check("setwins_ovf_a", 32'(ovf_a), 32'd1);
    check("setwins_ovf_b", 32'(ovf_b), 32'd1);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    check("clr_ovf_a", 32'(ovf_a), 32'd0);
    check("clr_tc_a",  32'(tc_a),  32'd0);

    // Down wrap with MODULUS 10 from load 2
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    check("down_load_b", 32'(cnt_b), 32'd2);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("down_cnt_b", 32'(cnt_b), (k == 1) ? 32'd1 : (k == 2) ? 32'd0 : (k == 3) ? 32'd9 : 32'd8);
      check("down_tc_b",  32'(tc_b),  (k == 3) ? 32'd1 : 32'd0);
    end
    check("down_cnt_a", 32'(cnt_a), 32'd14);

    // Saturate up from 14, then turn around
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 1'b1);
    tick();
    check("sat_load_a", 32'(cnt_a), 32'd14);
    check("sat_load_ovf_a", 32'(ovf_a), 32'd0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("sat_cnt_a", 32'(cnt_a), 32'd15);
      check("sat_tc_a",  32'(tc_a),  (k >= 2) ? 32'd1 : 32'd0);
    end
    check("sat_ovf_a", 32'(ovf_a), 32'd1);
    check("sat_cnt_b", 32'(cnt_b), 32'd9);
    up = 1'b0;
    tick();
    check("sat_down_a", 32'(cnt_a), 32'd14);
    check("sat_down_tc_a", 32'(tc_a), 32'd0);

    // Load clamp and load priority over enable
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0);
    tick();
    check("clamp12_cnt_a", 32'(cnt_a), 32'd12);
    check("clamp12_cnt_b", 32'(cnt_b), 32'd9);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    check("loadwins_cnt_a", 32'(cnt_a), 32'd5);
    check("loadwins_cnt_b", 32'(cnt_b), 32'd5);

    // Asynchronous reset mid-count at 7
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check("pre_rst_cnt_a", 32'(cnt_a), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("async_rst_tc_a",  32'(tc_a),  32'd0);
    check("async_rst_ovf_a", 32'(ovf_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt_a", 32'(cnt_a), 32'd1);
    check("post_rst_tc_a",  32'(tc_a),  32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
